// File: rtl/alt_ddrx_buffer_rdctl.sv
// Read-side controller for a write-ordered buffer RAM: issues RAM reads under credit and drains through a skid FIFO.
// Latency: write_valid to out_valid is RAM_READ_LATENCY+2 cycles minimum; one word per cycle sustained.
// Backpressure: out_ready low stalls the skid FIFO; issue credit stops new reads before the skid can overflow.
//
// Ports:
//   ctl_clk, ctl_reset          clock, asynchronous active-high reset
//   write_valid                 writer stored one word at its write pointer this cycle
//   read_address / read_data    RAM read port (data RAM_READ_LATENCY cycles after address)
//   out_valid/out_ready/out_data  drained words in write order, valid/ready handshake
//   word_count                  words written but not yet issued as RAM reads
//   buffer_full                 total occupancy equals buffer depth
//   err_overflow, err_underflow sticky consistency flags
//
// Optional feature: define ALT_DDRX_BUFFER_RDCTL_ERRCHK_EN to build the sticky error
// checkers; otherwise both error outputs are tied to 0.
module alt_ddrx_buffer_rdctl #(
    parameter int DATA_WIDTH       = 32,
    parameter int ADDR_WIDTH       = 4,
    parameter int RAM_READ_LATENCY = 2
) (
    input  logic                  ctl_clk,
    input  logic                  ctl_reset,
    input  logic                  write_valid,
    output logic [ADDR_WIDTH-1:0] read_address,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  buffer_full,
    output logic                  err_overflow,
    output logic                  err_underflow
);

    localparam int LAT        = RAM_READ_LATENCY;
    localparam int SKID_DEPTH = LAT + 1;
    localparam int SW         = $clog2(SKID_DEPTH);
    localparam int CW         = $clog2(SKID_DEPTH + 1);

    localparam logic [ADDR_WIDTH:0]   DEPTH     = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
    localparam logic [SW-1:0]         SKID_LAST = SW'(SKID_DEPTH - 1);
    localparam logic [SW-1:0]         SKID_ONE  = SW'(1);
    localparam logic [CW-1:0]         SCNT_ONE  = CW'(1);
    localparam logic [CW:0]           CREDITS   = (CW+1)'(SKID_DEPTH);

    logic [ADDR_WIDTH-1:0] rd_ptr_q;
    logic [ADDR_WIDTH:0]   word_cnt_q, word_cnt_d;
    logic [ADDR_WIDTH:0]   total_q, total_d;
    logic [LAT-1:0]        vld_pipe_q, vld_pipe_d;
    logic [DATA_WIDTH-1:0] skid_mem_q [SKID_DEPTH];
    logic [SW-1:0]         skid_wr_q, skid_rd_q;
    logic [CW-1:0]         skid_cnt_q, skid_cnt_d;

    logic          issue, push, pop;
    logic [CW-1:0] in_flight;
    logic [CW:0]   credit_used;

    assign pop  = (skid_cnt_q != '0) && out_ready;
    assign push = vld_pipe_q[LAT-1];

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < LAT; i++) begin
            in_flight = in_flight + CW'(vld_pipe_q[i]);
        end
    end

    // The slot freed by this cycle's pop is returned as credit immediately; without
    // that the pipe plus one skid entry would exhaust the credits in steady state and
    // throughput would drop below one word per cycle. Pipe+skid never exceeds SKID_DEPTH.
    assign credit_used = (CW+1)'(in_flight) + (CW+1)'(skid_cnt_q) - (CW+1)'(pop);
    // word_cnt_q is a register, so a word written this cycle cannot be issued until next cycle.
    assign issue       = (word_cnt_q != '0) && (credit_used < CREDITS);
    assign vld_pipe_d  = (vld_pipe_q << 1) | LAT'(issue);

    always_comb begin
        word_cnt_d = word_cnt_q;
        case ({write_valid, issue})
            2'b10:   word_cnt_d = word_cnt_q + CNT_ONE;
            2'b01:   word_cnt_d = word_cnt_q - CNT_ONE;
            default: word_cnt_d = word_cnt_q;
        endcase
    end

    // Total occupancy only shrinks when the consumer takes a word.
    always_comb begin
        total_d = total_q;
        case ({write_valid, pop})
            2'b10:   total_d = total_q + CNT_ONE;
            2'b01:   total_d = total_q - CNT_ONE;
            default: total_d = total_q;
        endcase
    end

    always_comb begin
        skid_cnt_d = skid_cnt_q;
        case ({push, pop})
            2'b10:   skid_cnt_d = skid_cnt_q + SCNT_ONE;
            2'b01:   skid_cnt_d = skid_cnt_q - SCNT_ONE;
            default: skid_cnt_d = skid_cnt_q;
        endcase
    end

    always_ff @(posedge ctl_clk or posedge ctl_reset) begin
        if (ctl_reset) begin
            rd_ptr_q   <= '0;
            word_cnt_q <= '0;
            total_q    <= '0;
            vld_pipe_q <= '0;
            skid_wr_q  <= '0;
            skid_rd_q  <= '0;
            skid_cnt_q <= '0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                skid_mem_q[i] <= '0;
            end
        end else begin
            word_cnt_q <= word_cnt_d;
            total_q    <= total_d;
            vld_pipe_q <= vld_pipe_d;
            skid_cnt_q <= skid_cnt_d;
            if (issue) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (push) begin
                skid_mem_q[skid_wr_q] <= read_data;
                skid_wr_q <= (skid_wr_q == SKID_LAST) ? '0 : skid_wr_q + SKID_ONE;
            end
            if (pop) begin
                skid_rd_q <= (skid_rd_q == SKID_LAST) ? '0 : skid_rd_q + SKID_ONE;
            end
        end
    end

    assign read_address = rd_ptr_q;
    assign word_count   = word_cnt_q;
    assign out_valid    = (skid_cnt_q != '0);
    assign out_data     = skid_mem_q[skid_rd_q];
    assign buffer_full  = (total_q == DEPTH);

`ifdef ALT_DDRX_BUFFER_RDCTL_ERRCHK_EN
    logic err_ovf_q, err_udf_q;

    // Underflow: a pop while the occupancy counter reads zero means the counter and
    // the skid FIFO have lost agreement.
    always_ff @(posedge ctl_clk or posedge ctl_reset) begin
        if (ctl_reset) begin
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            if (write_valid && buffer_full) begin
                err_ovf_q <= 1'b1;
            end
            if (pop && (total_q == '0)) begin
                err_udf_q <= 1'b1;
            end
        end
    end

    assign err_overflow  = err_ovf_q;
    assign err_underflow = err_udf_q;
`else
    assign err_overflow  = 1'b0;
    assign err_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_alt_ddrx_buffer_rdctl.sv
// Bench for alt_ddrx_buffer_rdctl: models the buffer RAM (registered, latency 2) and a
// writer, and scores drained words against the sequence written.
// Reference: written words in order, accepted words in order, occupancy = written - accepted.
module tb_alt_ddrx_buffer_rdctl;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int LAT   = 2;
    localparam int DEPTH = 16;
`ifdef ALT_DDRX_BUFFER_RDCTL_ERRCHK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    logic          ctl_clk;
    logic          ctl_reset;
    logic          write_valid;
    logic [AW-1:0] read_address;
    logic [DW-1:0] read_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW:0]   word_count;
    logic          buffer_full;
    logic          err_overflow;
    logic          err_underflow;

    alt_ddrx_buffer_rdctl #(
        .DATA_WIDTH      (DW),
        .ADDR_WIDTH      (AW),
        .RAM_READ_LATENCY(LAT)
    ) dut (
        .ctl_clk      (ctl_clk),
        .ctl_reset    (ctl_reset),
        .write_valid  (write_valid),
        .read_address (read_address),
        .read_data    (read_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .word_count   (word_count),
        .buffer_full  (buffer_full),
        .err_overflow (err_overflow),
        .err_underflow(err_underflow)
    );

    always #5 ctl_clk = ~ctl_clk;

    // Buffer RAM with a registered read port: two clock edges from address to data.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ram_q1;
    always @(posedge ctl_clk) begin
        ram_q1    <= mem[read_address];
        read_data <= ram_q1;
    end

    int            vectors;
    int            miscompares;
    int            wp;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];

    // One clock cycle: drive inputs at the falling edge, log an accept, advance to the next falling edge.
    task automatic cycle(input bit wv, input bit rdy, input logic [DW-1:0] d);
        write_valid = wv;
        out_ready   = rdy;
        if (wv) begin
            mem[wp] = d;
            exp_q.push_back(d);
            wp = (wp + 1) % DEPTH;
        end
        if (out_valid && rdy) got_q.push_back(out_data);
        @(negedge ctl_clk);
    endtask

    task automatic do_reset();
        ctl_reset   = 1'b1;
        write_valid = 1'b0;
        out_ready   = 1'b0;
        @(negedge ctl_clk);
        @(negedge ctl_clk);
        ctl_reset = 1'b0;
        wp = 0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < 200 && got_q.size() < n; k++) cycle(1'b0, 1'b1, '0);
    endtask

    task automatic test_reset();
        ctl_reset = 1'b1;
        @(negedge ctl_clk);
        vectors++;
        if (out_valid !== 1'b0 || out_data !== '0 || word_count !== '0 || buffer_full !== 1'b0 ||
            read_address !== '0 || err_overflow !== 1'b0 || err_underflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got vld=%b dat=%h wc=%0d full=%b ra=%0d eo=%b eu=%b, want all zero",
                     out_valid, out_data, word_count, buffer_full, read_address, err_overflow, err_underflow);
        end
        do_reset();
    endtask

    task automatic test_single();
        int k;
        do_reset();
        cycle(1'b1, 1'b1, 32'hA5A5_A5A5);
        k = 1;
        while (!out_valid && k < 20) begin
            cycle(1'b0, 1'b1, '0);
            k++;
        end
        vectors++;
        if (k !== LAT + 2) begin
            miscompares++;
            $display("FAIL single_latency: got %0d cycles, want %0d", k, LAT + 2);
        end
        vectors++;
        if (out_data !== 32'hA5A5_A5A5) begin
            miscompares++;
            $display("FAIL single_data: got %h want a5a5a5a5", out_data);
        end
        vectors++;
        if (word_count !== '0) begin
            miscompares++;
            $display("FAIL single_word_count: got %0d want 0", word_count);
        end
        drain(1);
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, $urandom());
        vectors++;
        if (buffer_full !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_full: got %b want 1", buffer_full);
        end
        vectors++;
        if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
            miscompares++;
            $display("FAIL fill_head: got vld=%b %h want vld=1 %h", out_valid, out_data, exp_q[0]);
        end
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, '0);
        vectors++;
        if (word_count !== (AW+1)'(DEPTH - (LAT + 1))) begin
            miscompares++;
            $display("FAIL fill_word_count: got %0d want %0d", word_count, DEPTH - (LAT + 1));
        end
        vectors++;
        if (out_data !== exp_q[0] || buffer_full !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_stable: got %h full=%b want %h full=1", out_data, buffer_full, exp_q[0]);
        end
        drain(DEPTH);
        vectors++;
        if (got_q.size() !== DEPTH) begin
            miscompares++;
            $display("FAIL fill_drain_count: got %0d want %0d", got_q.size(), DEPTH);
        end
        for (int i = 0; i < got_q.size() && i < DEPTH; i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL fill_order[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (buffer_full !== 1'b0 || word_count !== '0) begin
            miscompares++;
            $display("FAIL fill_empty: got full=%b wc=%0d want 0 0", buffer_full, word_count);
        end
    endtask

    task automatic test_stream();
        int            first_acc, last_acc;
        bit            saw_wrap;
        logic [AW-1:0] prev_ra;
        do_reset();
        first_acc = -1;
        last_acc  = -1;
        saw_wrap  = 1'b0;
        prev_ra   = read_address;
        for (int t = 0; t < 80 && got_q.size() < 20; t++) begin
            if (out_valid) begin
                if (first_acc < 0) first_acc = t;
                last_acc = t;
            end
            cycle(t < 20, 1'b1, 32'h1000_0000 + 32'(t));
            if (read_address !== prev_ra) begin
                vectors++;
                if (read_address !== prev_ra + AW'(1)) begin
                    miscompares++;
                    $display("FAIL stream_addr_step: got %0d want %0d", read_address, prev_ra + AW'(1));
                end
                if (prev_ra == AW'(DEPTH - 1) && read_address == '0) saw_wrap = 1'b1;
                prev_ra = read_address;
            end
        end
        vectors++;
        if (saw_wrap !== 1'b1) begin
            miscompares++;
            $display("FAIL stream_addr_wrap: got %b want 1", saw_wrap);
        end
        vectors++;
        if (got_q.size() !== 20) begin
            miscompares++;
            $display("FAIL stream_count: got %0d want 20", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < 20; i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL stream_order[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (last_acc - first_acc !== 19) begin
            miscompares++;
            $display("FAIL stream_throughput: got span %0d want 19", last_acc - first_acc);
        end
    endtask

    task automatic test_toggle_ready();
        bit            hold;
        logic [DW-1:0] held;
        do_reset();
        for (int t = 0; t < 100 && (t < 10 || got_q.size() < 10); t++) begin
            hold = out_valid && (t % 2 == 0);
            held = out_data;
            cycle(t < 10, t % 2 == 1, $urandom());
            if (hold) begin
                vectors++;
                if (out_valid !== 1'b1 || out_data !== held) begin
                    miscompares++;
                    $display("FAIL toggle_stable: got vld=%b %h want vld=1 %h", out_valid, out_data, held);
                end
            end
        end
        vectors++;
        if (got_q.size() !== 10) begin
            miscompares++;
            $display("FAIL toggle_count: got %0d want 10", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < 10; i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL toggle_order[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        bit            wv, rdy, hold;
        logic [DW-1:0] held;
        int            occ;
        do_reset();
        for (int t = 0; t < 400; t++) begin
            wv   = !buffer_full && ($urandom_range(0, 99) < 60);
            rdy  = ($urandom_range(0, 99) < 50);
            hold = out_valid && !rdy;
            held = out_data;
            cycle(wv, rdy, $urandom());
            occ = exp_q.size() - got_q.size();
            vectors++;
            if (buffer_full !== (occ == DEPTH)) begin
                miscompares++;
                $display("FAIL random_full t=%0d: got %b want %b (occupancy %0d)", t, buffer_full, occ == DEPTH, occ);
            end
            if (hold) begin
                vectors++;
                if (out_valid !== 1'b1 || out_data !== held) begin
                    miscompares++;
                    $display("FAIL random_stable t=%0d: got %h want %h", t, out_data, held);
                end
            end
        end
        drain(exp_q.size());
        vectors++;
        if (got_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL random_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL random_order[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'hDEAD_0000 + 32'(i));
        cycle(1'b0, 1'b0, '0);
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_pre_valid: got %b want 1", out_valid);
        end
        #1 ctl_reset = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || word_count !== '0 || read_address !== '0) begin
            miscompares++;
            $display("FAIL midreset_async: got vld=%b wc=%0d ra=%0d want 0 0 0", out_valid, word_count, read_address);
        end
        @(negedge ctl_clk);
        ctl_reset = 1'b0;
        wp = 0;
        exp_q.delete();
        got_q.delete();
        cycle(1'b1, 1'b1, 32'h5A5A_0001);
        drain(1);
        vectors++;
        if (got_q.size() !== 1 || got_q[0] !== 32'h5A5A_0001) begin
            miscompares++;
            $display("FAIL midreset_after: got %0d words first %h want 1 word 5a5a0001",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : '0);
        end
    endtask

    task automatic test_errchk();
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, $urandom());
        cycle(1'b1, 1'b0, $urandom());
        vectors++;
        if (err_overflow !== ERRCHK) begin
            miscompares++;
            $display("FAIL err_overflow_rise: got %b want %b", err_overflow, ERRCHK);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0);
        vectors++;
        if (err_overflow !== ERRCHK || err_underflow !== 1'b0) begin
            miscompares++;
            $display("FAIL err_sticky: got eo=%b eu=%b want eo=%b eu=0", err_overflow, err_underflow, ERRCHK);
        end
        do_reset();
        vectors++;
        if (err_overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL err_cleared: got %b want 0", err_overflow);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        ctl_clk     = 1'b0;
        ctl_reset   = 1'b1;
        write_valid = 1'b0;
        out_ready   = 1'b0;
        vectors     = 0;
        miscompares = 0;
        wp          = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_toggle_ready();
        test_random();
        test_reset_midstream();
        test_errchk();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
